// File: rtl/scan_sequencer.sv
// Scan sequencer: steps through cube positions, moving, settling, averaging RGB sensor bursts,
// then capturing translated colour codes into the cube-state buffer.
module scan_sequencer #(
   parameter int NUM_POSITIONS = 24,
   parameter int IDX_W         = 5,
   parameter int SETTLE_CYCLES = 1000,
   parameter int SAMPLE_SHIFT  = 2,
   parameter int XLATE_WAIT    = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   output logic             move_req,
   input  logic             move_done,
   input  logic             sample_valid,
   input  logic [23:0]      edge_rgb_in,
   input  logic [23:0]      corner_rgb_in,
   output logic [23:0]      edge_rgb_out,
   output logic [23:0]      corner_rgb_out,
   input  logic [2:0]       color_edge,
   input  logic [2:0]       color_corner,
   output logic             result_wr,
   output logic [IDX_W-1:0] result_idx,
   output logic [2:0]       result_edge,
   output logic [2:0]       result_corner,
   output logic             busy,
   output logic             done,
   output logic [2:0]       state_dbg
);

   // Handshakes: move_req stays high every cycle in MOVE and move_done is taken on any cycle
   // move_req is high (including its first); sample_valid qualifies both RGB inputs, SAMPLE only.

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MOVE   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_XLATE  = 3'd4,
      ST_WRITE  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   localparam int ACC_W  = 8 + SAMPLE_SHIFT;
   localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int SCNT_W = SAMPLE_SHIFT + 1;
   localparam int XCNT_W = (XLATE_WAIT > 1) ? $clog2(XLATE_WAIT) : 1;

   localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [SCNT_W-1:0] SAMPLE_LAST = SCNT_W'((1 << SAMPLE_SHIFT) - 1);
   localparam logic [XCNT_W-1:0] XLATE_LAST  = XCNT_W'(XLATE_WAIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_POSITIONS - 1);

   state_t state, state_next;

   logic [SET_W-1:0]  settle_cnt;
   logic [SCNT_W-1:0] sample_cnt;
   logic [XCNT_W-1:0] xlate_cnt;
   logic [ACC_W-1:0]  acc [6];
   logic [ACC_W-1:0]  sum [6];
   logic [7:0]        samp [6];
   logic [23:0]       avg_edge, avg_corner;

   // Channel order 0..5 = edge r,g,b then corner r,g,b; sum includes the current sample.
   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         samp[ch]     = edge_rgb_in[23-8*ch -: 8];
         samp[ch + 3] = corner_rgb_in[23-8*ch -: 8];
      end
      for (int ch = 0; ch < 6; ch++) begin
         sum[ch] = acc[ch] + ACC_W'(samp[ch]);
      end
   end

   assign avg_edge   = {sum[0][SAMPLE_SHIFT +: 8], sum[1][SAMPLE_SHIFT +: 8], sum[2][SAMPLE_SHIFT +: 8]};
   assign avg_corner = {sum[3][SAMPLE_SHIFT +: 8], sum[4][SAMPLE_SHIFT +: 8], sum[5][SAMPLE_SHIFT +: 8]};

   always_ff @(posedge clock) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (start) state_next = ST_SETTLE;
         ST_MOVE:   if (move_done) state_next = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = ST_SAMPLE;
         ST_SAMPLE: if (sample_valid && (sample_cnt == SAMPLE_LAST)) state_next = ST_XLATE;
         ST_XLATE:  if (xlate_cnt == XLATE_LAST) state_next = ST_WRITE;
         ST_WRITE:  state_next = (result_idx == IDX_LAST) ? ST_DONE : ST_MOVE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         settle_cnt     <= '0;
         sample_cnt     <= '0;
         xlate_cnt      <= '0;
         result_idx     <= '0;
         result_edge    <= '0;
         result_corner  <= '0;
         edge_rgb_out   <= '0;
         corner_rgb_out <= '0;
         for (int ch = 0; ch < 6; ch++) acc[ch] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               settle_cnt <= '0;
               result_idx <= '0;
            end
            ST_MOVE: settle_cnt <= '0;
            ST_SETTLE: begin
               // Clearing every settle cycle guarantees a clean accumulator on entry to SAMPLE.
               settle_cnt <= settle_cnt + 1'b1;
               sample_cnt <= '0;
               for (int ch = 0; ch < 6; ch++) acc[ch] <= '0;
            end
            ST_SAMPLE: begin
               xlate_cnt <= '0;
               if (sample_valid) begin
                  if (sample_cnt == SAMPLE_LAST) begin
                     edge_rgb_out   <= avg_edge;
                     corner_rgb_out <= avg_corner;
                  end else begin
                     sample_cnt <= sample_cnt + 1'b1;
                     for (int ch = 0; ch < 6; ch++) acc[ch] <= sum[ch];
                  end
               end
            end
            ST_XLATE: begin
               xlate_cnt <= xlate_cnt + 1'b1;
               if (xlate_cnt == XLATE_LAST) begin
                  result_edge   <= color_edge;
                  result_corner <= color_corner;
               end
            end
            ST_WRITE: if (result_idx != IDX_LAST) result_idx <= result_idx + 1'b1;
            ST_DONE:  result_idx <= '0;
            default:  ;
         endcase
      end
   end

   assign move_req  = (state == ST_MOVE);
   assign result_wr = (state == ST_WRITE);
   assign done      = (state == ST_DONE);
   assign busy      = (state != ST_IDLE) && (state != ST_DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: table of per-position sample bursts with hand-computed averages,
// a registered translator model, and a scoreboard checked on every result write.
module tb_scan_sequencer;
   localparam int NUM_POS = 2;
   localparam int IDX_W   = 5;
   localparam int SETTLE  = 3;
   localparam int SHIFT   = 2;
   localparam int XWAIT   = 2;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             move_done = 1'b0;
   logic             sample_valid = 1'b0;
   logic [23:0]      edge_rgb_in = '0;
   logic [23:0]      corner_rgb_in = '0;
   logic [2:0]       color_edge, color_corner;
   logic             move_req, result_wr, busy, done;
   logic [23:0]      edge_rgb_out, corner_rgb_out;
   logic [IDX_W-1:0] result_idx;
   logic [2:0]       result_edge, result_corner, state_dbg;

   scan_sequencer #(
      .NUM_POSITIONS(NUM_POS), .IDX_W(IDX_W), .SETTLE_CYCLES(SETTLE),
      .SAMPLE_SHIFT(SHIFT), .XLATE_WAIT(XWAIT)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .move_req(move_req),
      .move_done(move_done), .sample_valid(sample_valid), .edge_rgb_in(edge_rgb_in),
      .corner_rgb_in(corner_rgb_in), .edge_rgb_out(edge_rgb_out), .corner_rgb_out(corner_rgb_out),
      .color_edge(color_edge), .color_corner(color_corner), .result_wr(result_wr),
      .result_idx(result_idx), .result_edge(result_edge), .result_corner(result_corner),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // clock / reset and translator model (1-cycle registered: code = red channel low 3 bits)
   always #5 clock = ~clock;

   always @(posedge clock) begin
      color_edge   <= edge_rgb_out[18:16];
      color_corner <= corner_rgb_out[18:16];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   // stimulus table
   typedef struct packed {
      logic [3:0][23:0] e;
      logic [3:0][23:0] c;
      logic [23:0]      xe;
      logic [23:0]      xc;
      logic [7:0]       gap;
      logic             junk;
   } vec_t;

   vec_t vecs [6];

   function automatic vec_t mk(input logic [23:0] e0, e1, e2, e3, c0, c1, c2, c3, xe, xc,
                               input int gap, input logic junk);
      vec_t r;
      r.e    = {e3, e2, e1, e0};
      r.c    = {c3, c2, c1, c0};
      r.xe   = xe;
      r.xc   = xc;
      r.gap  = 8'(gap);
      r.junk = junk;
      return r;
   endfunction

   // scoreboard
   int          n_checks = 0;
   int          n_err = 0;
   logic [58:0] exp_q [$];
   int          mreq_cycles = 0;
   int          wr_in_scan = 0;
   int          done_count = 0;
   logic        prev_wr = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      logic [58:0] rec;
      if (move_req) mreq_cycles++;
      if (prev_wr) check("wr_width", {63'd0, result_wr}, 64'd0);
      prev_wr = result_wr;
      if (result_wr) begin
         wr_in_scan++;
         if (exp_q.size() == 0) begin
            check("unexpected_wr", {63'd0, result_wr}, 64'd0);
         end else begin
            rec = exp_q.pop_front();
            check("result_idx", 64'(result_idx), 64'(rec[58:54]));
            check("edge_rgb_out", 64'(edge_rgb_out), 64'(rec[53:30]));
            check("corner_rgb_out", 64'(corner_rgb_out), 64'(rec[29:6]));
            check("result_edge", 64'(result_edge), 64'(rec[5:3]));
            check("result_corner", 64'(result_corner), 64'(rec[2:0]));
            check("busy_at_wr", {63'd0, busy}, 64'd1);
            if (rec[58:54] == 5'd0) check("no_move_pos0", 64'(mreq_cycles), 64'd0);
         end
      end
      if (done) begin
         done_count++;
         check("busy_at_done", {63'd0, busy}, 64'd0);
         check("writes_per_scan", 64'(wr_in_scan), 64'(NUM_POS));
      end
   end

   // driver tasks
   task automatic do_start();
      @(negedge clock);
      start = 1'b1;
      mreq_cycles = 0;
      wr_in_scan = 0;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Entered on the negedge just after SETTLE begins; pushes the expected record when push=1.
   task automatic feed(input int v, input int p, input bit push);
      for (int i = 0; i < SETTLE; i++) begin
         sample_valid  = vecs[v].junk;
         edge_rgb_in   = '0;
         corner_rgb_in = '0;
         @(negedge clock);
      end
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < int'(vecs[v].gap); g++) begin
            sample_valid  = 1'b0;
            edge_rgb_in   = '0;
            corner_rgb_in = '0;
            @(negedge clock);
         end
         sample_valid  = 1'b1;
         edge_rgb_in   = vecs[v].e[i];
         corner_rgb_in = vecs[v].c[i];
         @(negedge clock);
      end
      sample_valid  = 1'b0;
      edge_rgb_in   = '0;
      corner_rgb_in = '0;
      if (push)
         exp_q.push_back({IDX_W'(p), vecs[v].xe, vecs[v].xc, vecs[v].xe[18:16], vecs[v].xc[18:16]});
   endtask

   task automatic wait_move_req();
      for (int i = 0; i < 300 && !move_req; i++) @(negedge clock);
      check("move_req_timeout", {63'd0, move_req}, 64'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 500 && !done; i++) @(negedge clock);
      check("done_timeout", {63'd0, done}, 64'd1);
   endtask

   task automatic accept_move();
      move_done = 1'b1;
      @(negedge clock);
      move_done = 1'b0;
      check("move_req_drop", {63'd0, move_req}, 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_move_req"}, {63'd0, move_req}, 64'd0);
      check({tag, "_result_wr"}, {63'd0, result_wr}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_idx"}, 64'(result_idx), 64'd0);
      check({tag, "_res_codes"}, 64'({result_edge, result_corner}), 64'd0);
      check({tag, "_rgb_out"}, {16'd0, edge_rgb_out, corner_rgb_out}, 64'd0);
   endtask

   initial begin
      int hi;
      int dc;
      vecs[0] = mk(24'h0A0064, 24'h0B0064, 24'h0C0064, 24'h0E0364,
                   24'h1401FF, 24'h1402FF, 24'h1403FF, 24'h1404FF,
                   24'h0B0064, 24'h1402FF, 0, 1'b0);
      vecs[1] = mk(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                   24'h088001, 24'h098001, 24'h0A8001, 24'h098002,
                   24'hFFFFFF, 24'h098001, 4, 1'b1);
      vecs[2] = mk(24'h081020, 24'h091020, 24'h0A1020, 24'h091020,
                   24'h0C3040, 24'h0D3040, 24'h0E3040, 24'h0D3041,
                   24'h091020, 24'h0D3040, 0, 1'b0);
      vecs[3] = mk(24'h01FF07, 24'h02FE07, 24'h03FF07, 24'h04FF07,
                   24'h050505, 24'h050505, 24'h050505, 24'h050505,
                   24'h02FE07, 24'h050505, 1, 1'b0);
      vecs[4] = mk(24'h112233, 24'h112233, 24'h112233, 24'h112233,
                   24'h445566, 24'h445566, 24'h465768, 24'h465768,
                   24'h112233, 24'h455667, 0, 1'b0);
      vecs[5] = mk(24'hFEFEFE, 24'hFFFFFF, 24'hFEFEFE, 24'hFFFFFF,
                   24'h000000, 24'h000000, 24'h000000, 24'h000003,
                   24'hFEFEFE, 24'h000000, 2, 1'b1);

      // reset state
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clock);

      // scan A: continuous then gapped samples, 50-cycle move hold-off with junk and a stray start
      do_start();
      check("busy_after_start", {63'd0, busy}, 64'd1);
      feed(0, 0, 1'b1);
      wait_move_req();
      hi = 0;
      for (int i = 0; i < 50; i++) begin
         sample_valid  = 1'b1;
         edge_rgb_in   = '0;
         corner_rgb_in = '0;
         start = (i == 20);
         if (move_req && busy) hi++;
         @(negedge clock);
      end
      sample_valid = 1'b0;
      start = 1'b0;
      check("move_req_held", 64'(hi), 64'd50);
      accept_move();
      feed(1, 1, 1'b1);
      wait_done();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("start_at_done_ignored", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clock);
      check("idle_after_scan", {63'd0, busy | move_req}, 64'd0);
      check("idx_back_to_0", 64'(result_idx), 64'd0);

      // scan B: move_done on the first move_req cycle
      do_start();
      feed(2, 0, 1'b1);
      wait_move_req();
      accept_move();
      feed(3, 1, 1'b1);
      wait_done();
      repeat (2) @(negedge clock);

      // scan C: reset during SAMPLE of position 1
      do_start();
      feed(4, 0, 1'b1);
      wait_move_req();
      accept_move();
      repeat (SETTLE) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         sample_valid  = 1'b1;
         edge_rgb_in   = vecs[0].e[i];
         corner_rgb_in = vecs[0].c[i];
         @(negedge clock);
      end
      sample_valid = 1'b0;
      reset_n = 1'b0;
      dc = done_count;
      @(negedge clock);
      check_all_zero("midreset");
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      check("no_done_after_reset", 64'(done_count), 64'(dc));
      check("no_wr_after_reset", 64'(wr_in_scan), 64'd1);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      // scan D: restart after reset begins at idx 0
      do_start();
      feed(5, 0, 1'b1);
      wait_move_req();
      accept_move();
      feed(0, 1, 1'b1);
      wait_done();
      repeat (5) @(negedge clock);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      check("total_done", 64'(done_count), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Sequences one full cube colour scan for the colour-translation datapath.
- At each scan position it does the following in order: requests a cube move from the motor controller, waits for the mechanics to settle, and averages a burst of edge and corner RGB sensor samples.
- It then drives the averaged values into the colour translator, captures the 3-bit edge and corner colour codes, and writes them to the cube-state buffer.
- It sits between the sensor front end, the motor controller, the colour translator and the cube-state RAM.

Parameters:
- NUM_POSITIONS, 24, number of scan positions per scan; each position yields one edge result and one corner result.
- IDX_W, 5, width of result_idx; must satisfy 2^IDX_W >= NUM_POSITIONS.
- SETTLE_CYCLES, 1000, clock cycles to wait after move_done before sampling begins; must be >= 1.
- SAMPLE_SHIFT, 2, log2 of the number of samples averaged per position (4 by default).
- XLATE_WAIT, 2, cycles the averaged RGB is held stable before the colour codes are captured; covers the translator's 1-cycle registered latency plus margin.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a scan; ignored while busy.
- move_req  out  1  request to the motor controller to advance to the next position.
- move_done  in  1  motor controller completion; honoured only in MOVE.
- sample_valid  in  1  sensor strobe qualifying edge_rgb_in and corner_rgb_in.
- edge_rgb_in  in  24  edge sensor sample, {r[7:0], g[7:0], b[7:0]}.
- corner_rgb_in  in  24  corner sensor sample, {r, g, b}.
- edge_rgb_out  out  24  averaged edge RGB presented to the translator, {r, g, b}.
- corner_rgb_out  out  24  averaged corner RGB presented to the translator.
- color_edge  in  3  edge colour code returned by the translator.
- color_corner  in  3  corner colour code returned by the translator.
- result_wr  out  1  one-cycle write strobe to the cube-state buffer.
- result_idx  out  IDX_W  position index of the current result.
- result_edge  out  3  captured edge colour code.
- result_corner  out  3  captured corner colour code.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last result is written.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: move_req, result_wr, result_idx, result_edge, result_corner, edge_rgb_out, corner_rgb_out, busy, done.
  - Accumulators and counters are cleared.
  - Reset mid-scan abandons the scan immediately: no result_wr and no done are issued, and move_req drops the next cycle.
- States are IDLE, MOVE, SETTLE, SAMPLE, XLATE, WRITE, DONE.
- IDLE:
  - start=1 moves to SETTLE with index 0. Position 0 has no move, because the cube is already presented.
  - busy goes to 1.
- MOVE:
  - move_req is 1 for every cycle spent in MOVE.
  - move_done=1 goes to SETTLE, and move_req is 0 on the next cycle.
  - move_done=1 on the same cycle move_req first rises is accepted.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then goes to SAMPLE.
  - sample_valid is ignored in this state.
- SAMPLE:
  - Each sample_valid=1 adds the 6 channels into per-channel accumulators, each 8+SAMPLE_SHIFT bits wide with no overflow.
  - After 2^SAMPLE_SHIFT accepted samples, each channel average is acc >> SAMPLE_SHIFT (truncating). The averages are registered into edge_rgb_out and corner_rgb_out, and the state goes to XLATE.
  - Accumulators are cleared on entry to SAMPLE.
  - Gaps in sample_valid simply stall the state.
- XLATE:
  - Holds the rgb outputs for XLATE_WAIT cycles.
  - On the last of those cycles, captures color_edge into result_edge and color_corner into result_corner, then goes to WRITE.
- WRITE:
  - result_wr=1 for exactly one cycle, with result_idx, result_edge and result_corner stable.
  - If result_idx == NUM_POSITIONS-1, goes to DONE.
  - Otherwise result_idx increments on the following cycle and the state goes to MOVE.
- DONE:
  - done=1 for one cycle and busy=0 on that same cycle, then IDLE.
  - result_idx returns to 0 and the rgb outputs hold their last value.
- Width rules:
  - result_idx never wraps past NUM_POSITIONS-1.
  - The settle counter is wide enough for SETTLE_CYCLES.
  - All arithmetic is unsigned.
- Boundary cases:
  - start while busy is ignored.
  - start on the same cycle as done is ignored.
  - move_done outside MOVE is ignored.
  - sample_valid outside SAMPLE is ignored.
  - There is no move timeout; MOVE waits indefinitely.

Test Plan:
- NUM_POSITIONS=2, SETTLE_CYCLES=3, SAMPLE_SHIFT=2, continuous sample_valid, translator modelled:
  - Required: no move_req for position 0.
  - Required: result_wr at idx 0, then move_req, then result_wr at idx 1, then done.
  - Required: busy spans the whole scan.
- Averaging: edge r samples 10, 11, 12, 14 (sum 47) -> edge_rgb_out r = 11.
  - All four samples 255 -> 255, with no overflow.
- Gapped sample_valid (one sample every 5 cycles) plus sample_valid pulses during SETTLE -> only the 4 SAMPLE-state samples are averaged.
- Translator model returns colour codes corner=5, edge=1 after 1 cycle -> result_corner=5, result_edge=1 written at the correct idx.
  - Also check: result_wr is exactly 1 cycle wide.
- move_done held off for 50 cycles -> move_req stays high for all 50 cycles.
  - Also check: no sampling occurs during the wait.
  - Also check: move_req drops the cycle after move_done.
- Reset:
  - reset_n low during SAMPLE of position 1 -> all outputs 0 next cycle, no done.
  - A new start after reset restarts at idx 0.
  - A second start pulse mid-scan has no effect.
